// File: rtl/prio_scan_pkg.sv
// Shared types and constants for the priority scan encoder.
//   state_t   : scan FSM state encoding (IDLE, SCAN)
//   SEG_BLANK : active-low seven-segment pattern with every segment and dp dark
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/prio_scan_encoder_hex7seg.sv
// Hex glyph lookup for a common-anode seven-segment digit.
//   nibble : 4-bit value to display
//   seg    : active-low {dp, g, f, e, d, c, b, a}; dp is always dark here,
//            the caller owns the decimal point.
module hex7seg (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        glyph = 7'b1111111;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
    end

    assign seg = {1'b1, glyph};

endmodule

// File: rtl/prio_scan_encoder.sv
// Priority scan encoder: accepts a request vector and emits the index of each
// set bit, highest first, one index per out handshake.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   en           : global enable, low freezes state and hides both handshakes
//   in_valid/in_ready/in_vec    : request vector input handshake
//   out_valid/out_ready/out_idx : index output handshake
//   out_last     : current beat carries the final index of the vector
//   zero_flag    : one-cycle pulse after an all-zero vector is accepted
//   hex0         : registered active-low digit of out_idx, dp lit on the last
//                  beat; only present when PRIO_SCAN_SEG_DISPLAY_EN is defined
//
// state | meaning
// IDLE  | waiting for a vector, in_ready follows en
// SCAN  | pending holds the bits still to be emitted, out_valid follows en
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_flag
`ifdef PRIO_SCAN_SEG_DISPLAY_EN
    ,
    output logic [7:0]       hex0
`endif
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [IDX_W-1:0] hi_idx;
    logic             single;
    logic             accept;
    logic             pop;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) hi_idx = IDX_W'(i);
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign single = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            zero_flag <= accept && (in_vec == '0);
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (accept && (in_vec != '0)) begin
                    state_nxt   = SCAN;
                    pending_nxt = in_vec;
                end
            end
            SCAN: begin
                if (pop) begin
                    pending_nxt[hi_idx] = 1'b0;
                    if (single) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = en && (state == IDLE);
        out_valid = en && (state == SCAN);
        out_idx   = out_valid ? hi_idx : '0;
        out_last  = out_valid && single;
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

`ifdef PRIO_SCAN_SEG_DISPLAY_EN
    logic [7:0] glyph;

    hex7seg u_hex7seg (
        .nibble (4'(out_idx)),
        .seg    (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hex0 <= SEG_BLANK;
        end else if (out_valid) begin
            hex0 <= {glyph[7] & ~out_last, glyph[6:0]};
        end else begin
            hex0 <= SEG_BLANK;
        end
    end
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Bench for prio_scan_encoder. Directed scenarios with literal expectations,
// then a randomized run; a queue-based reference model is checked against the
// DUT on every negative clock edge once reset has been applied.
// With PRIO_SCAN_SEG_DISPLAY_EN defined the DUT is built 16 bits wide and the
// display output is checked as well.
module tb_prio_scan_encoder;

`ifdef PRIO_SCAN_SEG_DISPLAY_EN
    localparam int W = 16;
`else
    localparam int W = 8;
`endif
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          zero_flag;
`ifdef PRIO_SCAN_SEG_DISPLAY_EN
    logic [7:0]    hex0;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model: indices still to emit, highest first.
    int       q[$];
    bit       m_zero = 1'b0;
    bit [7:0] m_hex  = 8'hFF;

    prio_scan_encoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_flag (zero_flag)
`ifdef PRIO_SCAN_SEG_DISPLAY_EN
        ,
        .hex0      (hex0)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic bit [6:0] glyph_of(input int v);
        bit [6:0] g;
        case (v)
            0: g = 7'b1000000;  1: g = 7'b1111001;  2: g = 7'b0100100;  3: g = 7'b0110000;
            4: g = 7'b0011001;  5: g = 7'b0010010;  6: g = 7'b0000010;  7: g = 7'b1111000;
            8: g = 7'b0000000;  9: g = 7'b0010000; 10: g = 7'b0001000; 11: g = 7'b0000011;
            12: g = 7'b1000110; 13: g = 7'b0100001; 14: g = 7'b0000110; 15: g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    always @(posedge clk) begin
        bit busy;
        bit vld;
        busy = (q.size() > 0);
        vld  = en && busy;
        if (rst) begin
            q.delete();
            m_zero = 1'b0;
            m_hex  = 8'hFF;
        end else begin
            m_hex  = vld ? {~(q.size() == 1), glyph_of(q[0])} : 8'hFF;
            m_zero = en && !busy && in_valid && (in_vec == '0);
            if (en && !busy && in_valid && (in_vec != '0)) begin
                for (int i = W - 1; i >= 0; i--) begin
                    if (in_vec[i]) q.push_back(i);
                end
            end else if (vld && out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit vld;
            vld = en && (q.size() > 0);
            check("in_ready",  32'(in_ready),  32'(en && (q.size() == 0)));
            check("out_valid", 32'(out_valid), 32'(vld));
            check("out_idx",   32'(out_idx),   vld ? 32'(q[0]) : 32'd0);
            check("out_last",  32'(out_last),  32'(vld && (q.size() == 1)));
            check("zero_flag", 32'(zero_flag), 32'(m_zero));
`ifdef PRIO_SCAN_SEG_DISPLAY_EN
            check("hex0",      32'(hex0),      32'(m_hex));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
`ifdef PRIO_SCAN_SEG_DISPLAY_EN
        check("rst_hex0",      32'(hex0),      32'hFF);
`endif

        // A2 drained at full rate: 7, 5, 1(last)
        in_valid = 1'b1; in_vec = 'hA2; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        @(negedge clk); check("a2_idx7", 32'(out_idx), 32'd7); check("a2_last7", 32'(out_last), 32'd0);
        check("a2_valid", 32'(out_valid), 32'd1); check("a2_busy", 32'(in_ready), 32'd0);
        step(); @(negedge clk); check("a2_idx5", 32'(out_idx), 32'd5);
        step(); @(negedge clk); check("a2_idx1", 32'(out_idx), 32'd1); check("a2_last1", 32'(out_last), 32'd1);
        step(); @(negedge clk); check("a2_ready", 32'(in_ready), 32'd1); check("a2_done", 32'(out_valid), 32'd0);

        // all-zero vector
        in_valid = 1'b1; in_vec = '0;
        step(); in_valid = 1'b0;
        @(negedge clk); check("zero_pulse", 32'(zero_flag), 32'd1);
        check("zero_novalid", 32'(out_valid), 32'd0); check("zero_idle", 32'(in_ready), 32'd1);
        step(); @(negedge clk); check("zero_clear", 32'(zero_flag), 32'd0);

        // 81 with three stalled cycles
        in_valid = 1'b1; in_vec = 'h81; out_ready = 1'b0;
        step(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("stall_hold7", 32'(out_idx), 32'd7);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk); check("stall_idx7", 32'(out_idx), 32'd7);
        step(); @(negedge clk); check("stall_idx0", 32'(out_idx), 32'd0); check("stall_last", 32'(out_last), 32'd1);
        step();

        // 0C with en low for two cycles right after accept
        in_valid = 1'b1; in_vec = 'h0C;
        step(); in_valid = 1'b0; en = 1'b0;
        @(negedge clk); check("en_off_valid", 32'(out_valid), 32'd0); check("en_off_ready", 32'(in_ready), 32'd0);
        step(); @(negedge clk); check("en_off_valid2", 32'(out_valid), 32'd0);
        step(); en = 1'b1;
        @(negedge clk); check("en_resume3", 32'(out_idx), 32'd3);
        step(); @(negedge clk); check("en_resume2", 32'(out_idx), 32'd2); check("en_last2", 32'(out_last), 32'd1);
        step();

        // reset in the middle of F0
        in_valid = 1'b1; in_vec = 'hF0;
        step(); in_valid = 1'b0;
        step(); @(negedge clk); check("mid_idx6", 32'(out_idx), 32'd6);
        rst = 1'b1;
        step(); @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0); check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        step(); @(negedge clk); check("mid_rst_stale", 32'(out_valid), 32'd0);

`ifdef PRIO_SCAN_SEG_DISPLAY_EN
        // 8001 on the 16-bit build with the digit display
        in_valid = 1'b1; in_vec = 'h8001; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        @(negedge clk); check("hx_idx15", 32'(out_idx), 32'd15); check("hx_blank", 32'(hex0), 32'hFF);
        step(); @(negedge clk); check("hx_idx0", 32'(out_idx), 32'd0); check("hx_F", 32'(hex0), 32'h8E);
        step(); @(negedge clk); check("hx_0dp", 32'(hex0), 32'h40);
        step(); @(negedge clk); check("hx_blank2", 32'(hex0), 32'hFF);
`endif

        // randomized traffic, model-checked every cycle
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(99) < 2);
            en        = ($urandom_range(9) != 0);
            in_valid  = ($urandom_range(1) == 1);
            in_vec    = W'($urandom);
            if ($urandom_range(5) == 0) in_vec = '0;
            if ($urandom_range(3) == 0) in_vec = in_vec & W'($urandom);
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_scan_encoder.md
PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the request vector width; legal range 2..16.
REQ-002 SHALL have derived localparam IDX_W, default $clog2(WIDTH), meaning the index width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block has one clock only.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port en  input  1  global enable; low freezes the block.
REQ-006 SHALL have port in_valid  input  1  request vector offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port in_vec  input  WIDTH  request bits; bit WIDTH-1 has the highest priority.
REQ-009 SHALL have port out_valid  output  1  out_idx is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_idx.
REQ-011 SHALL have port out_idx  output  IDX_W  index of the highest pending set bit.
REQ-012 SHALL have port out_last  output  1  the current beat is the final index of the vector.
REQ-013 SHALL have port zero_flag  output  1  one-cycle pulse when an all-zero vector is accepted.
REQ-014 SHALL have port hex0  output  8  active-low seven-segment plus dp; present only under the macro in REQ-030.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and SCAN, plus a WIDTH-bit pending register.
REQ-016 SHALL drive in_ready = en && state==IDLE.
REQ-017 SHALL, on in_valid && in_ready with in_vec==0, stay in IDLE and assert zero_flag in the next cycle only.
REQ-018 SHALL, on in_valid && in_ready with in_vec!=0, load pending<=in_vec and enter SCAN.
REQ-019 SHALL drive out_valid = en && state==SCAN, which gives one-cycle latency from accept to first out_valid.
REQ-020 SHALL drive out_idx from the highest set bit of pending, combinationally from the register, and hold it stable while out_valid && !out_ready.
REQ-021 SHALL, on out_valid && out_ready, clear bit out_idx of pending, so exactly one index is emitted per handshake, highest first.
REQ-022 SHALL assert out_last when pending has exactly one bit set; the handshake on that beat returns the FSM to IDLE.
REQ-023 SHALL, with en low, hold the state and pending unchanged, deassert in_ready and out_valid, and ignore in_valid and out_ready.
REQ-024 SHALL drive out_idx=0 and out_last=0 whenever out_valid is low.
REQ-025 SHALL accept no new vector during SCAN; the fastest back-to-back rate is one vector every popcount+1 cycles.

Reset
REQ-026 SHALL, on rst high at a clk edge, set state=IDLE, pending=0 and zero_flag=0, overriding en and all handshakes.
REQ-027 SHALL, after reset, give in_ready=en, out_valid=0, out_idx=0, out_last=0 and hex0=8'hFF.
REQ-028 SHALL, on reset mid-SCAN, discard the pending bits, with no out_valid in the following cycle.

Configuration
REQ-029 SHALL have no display logic and no hex0 port when macro PRIO_SCAN_SEG_DISPLAY_EN is undefined.
REQ-030 SHALL, when PRIO_SCAN_SEG_DISPLAY_EN is defined, register hex0 each cycle as the active-low hex glyph of out_idx while out_valid is high, else 8'hFF (blank).
REQ-031 SHALL, when PRIO_SCAN_SEG_DISPLAY_EN is defined, drive the dp segment low while out_last is high; hex0 lags out_idx by one cycle.

Structure
REQ-032 SHALL place the state enum (IDLE, SCAN) and the SEG_BLANK=8'hFF constant in package prio_scan_pkg.
REQ-033 SHALL implement the glyph lookup in a sub-module hex7seg (4-bit in, 8-bit active-low out), instantiated only under the macro.
REQ-034 SHALL implement the priority search as a parametrised loop, with no per-WIDTH case tables.

Verification
REQ-035 SHALL cover: WIDTH=8, in_vec=8'b1010_0010, out_ready=1 -> out_idx 7,5,1 on consecutive cycles; out_last on idx 1; then in_ready=1.
REQ-036 SHALL cover: in_vec=8'h00 accepted -> zero_flag pulses for one cycle, out_valid stays 0, and the FSM stays in IDLE.
REQ-037 SHALL cover: in_vec=8'h81, out_ready low for 3 cycles -> out_idx holds 7 stably, then 7,0 are emitted after out_ready rises.
REQ-038 SHALL cover: en dropped for 2 cycles mid-SCAN with in_vec=8'h0C -> out_valid=0 meanwhile, then the sequence resumes at the same index (3 then 2).
REQ-039 SHALL cover: rst asserted while pending=8'hF0 after one beat -> the next cycle shows out_valid=0 and in_ready=1, and no stale index appears.
REQ-040 SHALL cover: WIDTH=16, macro defined, in_vec=16'h8001 -> out_idx 15,0, with hex0 showing the "F" then "0" glyphs and dp low on the "0" beat.
